led_breathe_pwm: RTL and testbench

- Downstream consumer of the clock_divider output (clk_out).
- Samples the divided clock as a data signal in the fast clk_in domain and turns each rising edge into a one-cycle tick.
- Uses the ticks to step a breathing (ramp up / hold / ramp down / hold) duty cycle.
- Drives one board LED with glitch-free PWM at clk_in rate.

---
 rtl/led_breathe_pwm.sv | 98 +++++++++
 tb/tb_led_breathe_pwm.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/led_breathe_pwm.sv
// led_breathe_pwm: turns rising edges of a slow divided clock into ticks that step a
// breathing duty cycle, which drives one LED through a glitch-free PWM at clk_in rate.
module led_breathe_pwm #(
  parameter int PWM_BITS   = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                slow_clk,
  input  logic                enable,
  output logic                led_out,
  output logic [PWM_BITS-1:0] duty,
  output logic                tick_out
);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS + 1)'(STEP);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [2:0] {IDLE, RISE, HOLD_HI, FALL, HOLD_LO} state_t;

  state_t state, state_n;
  logic s1, s2, s3, armed;
  logic [1:0] vld;
  logic [PWM_BITS-1:0] pwm_cnt, active_duty, duty_n;
  logic [PWM_BITS:0] sum;
  logic [HW-1:0] hold_cnt, hold_n;

  // armed blocks a false tick when slow_clk is already high as reset releases
  assign tick_out = s2 & ~s3 & armed;
  assign sum = {1'b0, duty} + STEP_W;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      vld         <= '0;
      armed       <= 1'b0;
      pwm_cnt     <= '0;
      active_duty <= '0;
      led_out     <= ACTIVE_LOW;
      state       <= IDLE;
      duty        <= '0;
      hold_cnt    <= '0;
    end else begin
      s1          <= slow_clk;
      s2          <= s1;
      s3          <= s2;
      vld         <= {vld[0], 1'b1};
      armed       <= armed | (vld[1] & ~s2);
      pwm_cnt     <= pwm_cnt + 1'b1;
      active_duty <= (pwm_cnt == MAX) ? duty : active_duty;
      led_out     <= (pwm_cnt < active_duty) ^ ACTIVE_LOW;
      state       <= state_n;
      duty        <= duty_n;
      hold_cnt    <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    duty_n  = duty;
    hold_n  = hold_cnt;
    if (!enable) begin
      state_n = IDLE;
      duty_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          duty_n  = '0;
          state_n = RISE;
        end
        RISE: if (tick_out) begin
          if (sum >= {1'b0, MAX}) begin
            duty_n  = MAX;
            hold_n  = '0;
            state_n = HOLD_HI;
          end else duty_n = sum[PWM_BITS-1:0];
        end
        HOLD_HI, HOLD_LO: if (tick_out) begin
          hold_n = hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) state_n = (state == HOLD_HI) ? FALL : RISE;
        end
        FALL: if (tick_out) begin
          if ({1'b0, duty} <= STEP_W) begin
            duty_n  = '0;
            hold_n  = '0;
            state_n = HOLD_LO;
          end else duty_n = duty - STEP_W[PWM_BITS-1:0];
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_breathe_pwm.sv
// tb_led_breathe_pwm: directed checks of tick generation, breathing sequence, shadow duty,
// enable drop, async reset and a full-swing STEP instance.
module tb_led_breathe_pwm;
  logic clk_in = 0, rst_n = 0, man = 1, div_q = 0, div_on = 0, enable = 0, en15 = 0;
  logic slow_clk, led_out, tick_out, led15, tick15;
  logic [3:0] duty, duty15, pc;
  int total = 0, bad = 0, dcnt = 0, cyc = 0, lit = 0, tk = 0, last = 0;
  int seq [12] = '{4, 8, 12, 15, 15, 15, 11, 7, 3, 0, 0, 0};
  int seq15 [7] = '{15, 15, 15, 0, 0, 0, 15};

  assign slow_clk = div_on ? div_q : man;

  led_breathe_pwm #(.PWM_BITS(4), .STEP(4), .HOLD_TICKS(2), .ACTIVE_LOW(1'b1)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .slow_clk(slow_clk), .enable(enable),
    .led_out(led_out), .duty(duty), .tick_out(tick_out)
  );

  led_breathe_pwm #(.PWM_BITS(4), .STEP(15), .HOLD_TICKS(2), .ACTIVE_LOW(1'b1)) dut15 (
    .clk_in(clk_in), .rst_n(rst_n), .slow_clk(slow_clk), .enable(en15),
    .led_out(led15), .duty(duty15), .tick_out(tick15)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // reference PWM phase: free-running count of edges since reset release
  always @(posedge clk_in or negedge rst_n)
    if (!rst_n) pc <= '0;
    else pc <= pc + 4'd1;

  // divide-by-5 source standing in for clock_divider
  always @(negedge clk_in)
    if (div_on) begin
      dcnt = (dcnt == 4) ? 0 : dcnt + 1;
      div_q = (dcnt < 2);
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    int n = 0;
    while (tick_out !== 1'b1 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    if (tick_out !== 1'b1) check("tick_timeout", 32'(tick_out), 1);
  endtask

  task automatic pulse();
    man = 1;
    repeat (3) @(negedge clk_in);
    man = 0;
    repeat (3) @(negedge clk_in);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    check("rst_led", 32'(led_out), 1);
    check("rst_duty", 32'(duty), 0);
    check("rst_tick", 32'(tick_out), 0);
    check("rst_tick15", 32'(tick15), 0);
    rst_n = 1;
    repeat (8) begin
      @(negedge clk_in);
      tk += int'(tick_out);
    end
    check("no_tick_high_at_release", tk, 0);
    man = 0;
    repeat (4) @(negedge clk_in);
    man = 1;
    @(negedge clk_in); check("tick_e0", 32'(tick_out), 0);
    @(negedge clk_in); check("tick_e1", 32'(tick_out), 1);
    @(negedge clk_in); check("tick_e2", 32'(tick_out), 0);
    man = 0;
    tk = 0;
    repeat (4) begin
      @(negedge clk_in);
      tk += int'(tick_out);
    end
    check("fall_ignored", tk, 0);
    div_on = 1;
    tk = 0;
    lit = 0;
    repeat (200) begin
      @(negedge clk_in);
      tk += int'(tick_out);
      lit += int'(led_out !== 1'b1) + int'(duty !== 4'd0);
    end
    check("ticks_200", tk, 40);
    check("off_while_disabled", lit, 0);
    wait_tick();
    enable = 1;
    last = cyc;
    @(negedge clk_in);
    for (int i = 0; i < 26; i++) begin
      wait_tick();
      check("tick_gap", cyc - last, 5);
      last = cyc;
      @(negedge clk_in);
      check($sformatf("breathe_%0d", i), 32'(duty), seq[i % 12]);
    end
    enable = 0;
    @(negedge clk_in);
    check("disable_duty", 32'(duty), 0);
    div_on = 0;
    man = 0;
    repeat (6) @(negedge clk_in);
    enable = 1;
    repeat (3) @(negedge clk_in);
    pulse();
    check("step_4", 32'(duty), 4);
    @(negedge clk_in);
    while (pc != 4'd0) @(negedge clk_in);
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_in);
      lit += int'(led_out == 1'b0);
      man = (i >= 3 && i < 6);
    end
    check("period_old_duty", lit, 4);
    check("step_8", 32'(duty), 8);
    lit = 0;
    repeat (16) begin
      @(negedge clk_in);
      lit += int'(led_out == 1'b0);
    end
    check("period_new_duty", lit, 8);
    man = 1;
    wait_tick();
    enable = 0;
    @(negedge clk_in);
    check("drop_duty", 32'(duty), 0);
    man = 0;
    repeat (17) @(negedge clk_in);
    lit = 0;
    repeat (32) begin
      @(negedge clk_in);
      lit += int'(led_out == 1'b0);
    end
    check("dark_after_drop", lit, 0);
    pulse();
    check("idle_ignores_tick", 32'(duty), 0);
    enable = 1;
    repeat (2) @(negedge clk_in);
    pulse();
    check("restart_rise", 32'(duty), 4);
    pulse();
    check("rise_8", 32'(duty), 8);
    pulse();
    pulse();
    check("hold_hi", 32'(duty), 15);
    repeat (20) @(negedge clk_in);
    lit = 0;
    while (led_out !== 1'b0 && lit < 20) begin
      @(negedge clk_in);
      lit++;
    end
    check("lit_before_rst", 32'(led_out), 0);
    rst_n = 0;
    #1;
    check("async_rst_led", 32'(led_out), 1);
    check("async_rst_duty", 32'(duty), 0);
    @(negedge clk_in);
    rst_n = 1;
    repeat (4) @(negedge clk_in);
    check("post_rst_duty", 32'(duty), 0);
    pulse();
    check("post_rst_rise", 32'(duty), 4);
    en15 = 1;
    repeat (3) @(negedge clk_in);
    for (int i = 0; i < 7; i++) begin
      pulse();
      check($sformatf("step15_%0d", i), 32'(duty15), seq15[i]);
    end
    repeat (20) @(negedge clk_in);
    lit = 0;
    repeat (16) begin
      @(negedge clk_in);
      lit += int'(led15 == 1'b0);
    end
    check("full_duty_lit", lit, 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
